// File: rtl/apb_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_if
//  Brief    : APB4 bus bundle between a bridge/decoder and one memory target.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_slave
//  Brief    : Parametrised APB4 RAM target with byte strobes, programmable
//             wait states and PSLVERR on out-of-range word addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  wire logic   clk,
    input  wire logic   res,
    apb_mem_if.slave    bus
);
    localparam int         C_STRB_W = DATA_W / 8;
    localparam int         C_OFF_W  = $clog2(C_STRB_W);
    localparam int         C_IDX_W  = ADDR_W - C_OFF_W;
    localparam int         C_MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_WAIT   = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_W-1:0]      prdata_q, prdata_d;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;
    logic [C_MEM_AW-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [C_STRB_W-1:0]    strb_q, strb_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic                   w_mem_we;
    logic                   w_raise;
    logic [C_IDX_W-1:0]     w_setup_idx;
    logic                   w_setup_err;
    logic [C_MEM_AW-1:0]    w_rd_idx;
    logic                   w_rd_err;
    logic                   w_rd_wr;
    logic                   w_unused_paddr;

    // Byte-offset bits are deliberately dropped: no misalignment checking.
    assign w_unused_paddr = ^bus.paddr;
    assign w_setup_idx    = bus.paddr[ADDR_W-1:C_OFF_W];
    assign w_setup_err    = ({1'b0, w_setup_idx} >= (C_IDX_W + 1)'(DEPTH));

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

    // Next-state, latched transfer attributes and registered response values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        wr_d      = wr_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        w_mem_we  = 1'b0;
        w_raise   = 1'b0;
        w_rd_idx  = idx_q;
        w_rd_err  = err_q;
        w_rd_wr   = wr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d = S_ACCESS;
                    wr_d    = bus.pwrite;
                    err_d   = w_setup_err;
                    idx_d   = w_setup_idx[C_MEM_AW-1:0];
                    wdata_d = bus.pwdata;
                    strb_d  = bus.pstrb;
                    if (WAIT_STATES == 0) begin
                        // Zero-wait: respond straight from the SETUP inputs.
                        w_raise  = 1'b1;
                        w_rd_idx = w_setup_idx[C_MEM_AW-1:0];
                        w_rd_err = w_setup_err;
                        w_rd_wr  = bus.pwrite;
                    end else begin
                        cnt_d = C_WAIT;
                    end
                end
            end
            S_ACCESS: begin
                if (!bus.psel) begin
                    // Master walked away: drop the transfer, memory untouched.
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    cnt_d     = 4'd0;
                end else if (pready_q) begin
                    if (bus.penable) begin
                        state_d   = S_IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        w_mem_we  = wr_q && !err_q;
                    end
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    w_raise = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_raise) begin
            pready_d  = 1'b1;
            pslverr_d = w_rd_err;
            if (!w_rd_wr) begin
                prdata_d = w_rd_err ? '0 : mem_q[w_rd_idx];
            end
        end
    end

    // Control and response registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
        end
    end

    // Storage array: cleared on reset, byte-lane writes on write completion.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_mem_we) begin
            for (int l = 0; l < C_STRB_W; l++) begin
                if (strb_q[l]) begin
                    mem_q[idx_q][8*l +: 8] <= wdata_q[8*l +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire
